network_bf_in: RTL and testbench

NETWORK_BF_IN -- requirements
Module: network_bf_in

---
 rtl/network_bf_in.sv | 168 ++++++++++++++++
 tb/tb_network_bf_in.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/network_bf_in.sv
// rtl/network_bf_in.sv - memory-to-butterfly input network with aligned select delay line
// Optional duplicate-select checker: define NETWORK_BF_IN_CHK_EN
module network_bf_in #(
    parameter int data_width = 14,
    parameter int MEM_LAT    = 2,
    parameter int BEATS      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] d0,
    input  logic [data_width-1:0] d1,
    input  logic [data_width-1:0] d2,
    input  logic [data_width-1:0] d3,
    input  logic [data_width-1:0] d4,
    input  logic [data_width-1:0] d5,
    input  logic [data_width-1:0] d6,
    input  logic [data_width-1:0] d7,
    input  logic [2:0]            sel_b_0,
    input  logic [2:0]            sel_b_1,
    input  logic [2:0]            sel_b_2,
    input  logic [2:0]            sel_b_3,
    input  logic [2:0]            sel_b_4,
    input  logic [2:0]            sel_b_5,
    input  logic [2:0]            sel_b_6,
    input  logic [2:0]            sel_b_7,
    input  logic                  in_valid,
    input  logic                  stage_clr,
    output logic [data_width-1:0] bf_0_upper,
    output logic [data_width-1:0] bf_0_lower,
    output logic [data_width-1:0] bf_1_upper,
    output logic [data_width-1:0] bf_1_lower,
    output logic [data_width-1:0] bf_2_upper,
    output logic [data_width-1:0] bf_2_lower,
    output logic [data_width-1:0] bf_3_upper,
    output logic [data_width-1:0] bf_3_lower,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [7:0]            beat_cnt,
    output logic                  sel_err
);

    localparam logic [7:0] LAST_BEAT = 8'(BEATS - 1);

    logic [2:0]            sel_in   [8];
    logic [data_width-1:0] lane     [8];
    logic [2:0]            sel_pipe [MEM_LAT][8];
    logic [MEM_LAT-1:0]    vld_pipe;
    logic [data_width-1:0] routed   [8];
    logic [data_width-1:0] bf_q     [8];
    logic                  aligned_valid;

    assign sel_in[0] = sel_b_0;
    assign sel_in[1] = sel_b_1;
    assign sel_in[2] = sel_b_2;
    assign sel_in[3] = sel_b_3;
    assign sel_in[4] = sel_b_4;
    assign sel_in[5] = sel_b_5;
    assign sel_in[6] = sel_b_6;
    assign sel_in[7] = sel_b_7;

    assign lane[0] = d0;
    assign lane[1] = d1;
    assign lane[2] = d2;
    assign lane[3] = d3;
    assign lane[4] = d4;
    assign lane[5] = d5;
    assign lane[6] = d6;
    assign lane[7] = d7;

    assign aligned_valid = vld_pipe[MEM_LAT-1];

    // Delay selects and valid by the memory latency so they meet the read data
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                for (int k = 0; k < 8; k++) begin
                    sel_pipe[i][k] <= 3'd0;
                end
            end
        end else begin
            vld_pipe[0] <= in_valid;
            for (int k = 0; k < 8; k++) begin
                sel_pipe[0][k] <= sel_in[k];
            end
            for (int i = 1; i < MEM_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                for (int k = 0; k < 8; k++) begin
                    sel_pipe[i][k] <= sel_pipe[i-1][k];
                end
            end
        end
    end

    // Crossbar: each BFU port picks the lane named by its aligned select
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            routed[k] = lane[sel_pipe[MEM_LAT-1][k]];
        end
    end

    // Output register; data holds across bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                bf_q[k] <= '0;
            end
        end else begin
            out_valid <= aligned_valid;
            if (aligned_valid) begin
                for (int k = 0; k < 8; k++) begin
                    bf_q[k] <= routed[k];
                end
            end
        end
    end

    // Beat counter; stage_clr wins over the increment of a coincident beat
    always_ff @(posedge clk) begin
        if (rst || stage_clr) begin
            beat_cnt <= 8'd0;
        end else if (out_valid) begin
            beat_cnt <= (beat_cnt == LAST_BEAT) ? 8'd0 : beat_cnt + 8'd1;
        end
    end

    assign out_last = out_valid && (beat_cnt == LAST_BEAT);

    assign bf_0_upper = bf_q[0];
    assign bf_0_lower = bf_q[1];
    assign bf_1_upper = bf_q[2];
    assign bf_1_lower = bf_q[3];
    assign bf_2_upper = bf_q[4];
    assign bf_2_lower = bf_q[5];
    assign bf_3_upper = bf_q[6];
    assign bf_3_lower = bf_q[7];

`ifdef NETWORK_BF_IN_CHK_EN
    logic sel_dup;

    // Any two aligned selects equal means one lane would feed two ports
    always_comb begin
        sel_dup = 1'b0;
        for (int a = 0; a < 8; a++) begin
            for (int b = a + 1; b < 8; b++) begin
                if (sel_pipe[MEM_LAT-1][a] == sel_pipe[MEM_LAT-1][b]) begin
                    sel_dup = 1'b1;
                end
            end
        end
    end

    // Sticky error; a fresh duplicate beats a coincident stage_clr
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (aligned_valid && sel_dup) begin
            sel_err <= 1'b1;
        end else if (stage_clr) begin
            sel_err <= 1'b0;
        end
    end
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_network_bf_in.sv
// tb/tb_network_bf_in.sv - self-checking bench for network_bf_in
module tb_network_bf_in;

    localparam int DW  = 14;
    localparam int LAT = 2;
    localparam int NB  = 4;
    localparam int HN  = 4096;
`ifdef NETWORK_BF_IN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, in_valid, stage_clr;
    logic [DW-1:0] d   [8];
    logic [2:0]    sel [8];
    logic [DW-1:0] bf  [8];
    logic          out_valid, out_last, sel_err;
    logic [7:0]    beat_cnt;

    always #5 clk = ~clk;

    network_bf_in #(.data_width(DW), .MEM_LAT(LAT), .BEATS(NB)) dut (
        .clk(clk), .rst(rst),
        .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
        .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
        .sel_b_0(sel[0]), .sel_b_1(sel[1]), .sel_b_2(sel[2]), .sel_b_3(sel[3]),
        .sel_b_4(sel[4]), .sel_b_5(sel[5]), .sel_b_6(sel[6]), .sel_b_7(sel[7]),
        .in_valid(in_valid), .stage_clr(stage_clr),
        .bf_0_upper(bf[0]), .bf_0_lower(bf[1]), .bf_1_upper(bf[2]), .bf_1_lower(bf[3]),
        .bf_2_upper(bf[4]), .bf_2_lower(bf[5]), .bf_3_upper(bf[6]), .bf_3_lower(bf[7]),
        .out_valid(out_valid), .out_last(out_last), .beat_cnt(beat_cnt), .sel_err(sel_err)
    );

    // Reference model: per-cycle history of issued reads and arriving data
    bit            h_vld [HN];
    logic [2:0]    h_sel [HN][8];
    logic [DW-1:0] h_d   [HN][8];
    logic [DW-1:0] exp_bf [8];
    bit            exp_valid, exp_err;
    int            exp_cnt;
    int            t;
    int            total, bad;

    typedef struct {
        bit r, v, c, rev;
        bit ev;
        int ecnt;
        bit elast;
        int eb0, eb3;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", name, t, act, want);
        end
    endtask

    function automatic bit has_dup(input int idx);
        bit r = 1'b0;
        for (int a = 0; a < 8; a++)
            for (int b = a + 1; b < 8; b++)
                if (h_sel[idx][a] == h_sel[idx][b]) r = 1'b1;
        return r;
    endfunction

    task automatic model_step();
        bit av;
        bit old_valid;
        for (int k = 0; k < 8; k++) begin
            h_sel[t][k] = sel[k];
            h_d[t][k]   = d[k];
        end
        h_vld[t]  = in_valid;
        old_valid = exp_valid;
        if (rst) begin
            for (int j = t - LAT; j <= t; j++) if (j >= 0) h_vld[j] = 1'b0;
            for (int k = 0; k < 8; k++) exp_bf[k] = '0;
            exp_valid = 1'b0;
            exp_cnt   = 0;
            exp_err   = 1'b0;
        end else begin
            av = (t >= LAT) && h_vld[t-LAT];
            if (stage_clr)      exp_cnt = 0;
            else if (old_valid) exp_cnt = (exp_cnt + 1) % NB;
            if (CHK) begin
                if (av && has_dup(t - LAT)) exp_err = 1'b1;
                else if (stage_clr)         exp_err = 1'b0;
            end
            if (av)
                for (int k = 0; k < 8; k++) exp_bf[k] = h_d[t][h_sel[t-LAT][k]];
            exp_valid = av;
        end
        t++;
    endtask

    task automatic check_model();
        chk("out_valid", int'(out_valid), int'(exp_valid));
        chk("out_last", int'(out_last), int'(exp_valid && exp_cnt == NB - 1));
        chk("beat_cnt", int'(beat_cnt), exp_cnt);
        chk("sel_err", int'(sel_err), int'(exp_err));
        for (int k = 0; k < 8; k++) chk($sformatf("bf%0d", k), int'(bf[k]), int'(exp_bf[k]));
    endtask

    task automatic tick(input bit r, input bit v, input bit c);
        rst = r; in_valid = v; stage_clr = c;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic set_sel(input int mode);
        for (int k = 0; k < 8; k++) begin
            case (mode)
                0:       sel[k] = 3'(k);
                1:       sel[k] = 3'(7 - k);
                default: sel[k] = 3'((k == 7) ? 6 : k);
            endcase
        end
    endtask

    task automatic rand_data();
        for (int k = 0; k < 8; k++) d[k] = DW'($urandom);
    endtask

    int q_cnt [$];
    int q_last [$];
    int beats;
    bit clr_now;
    int p [8];

    initial begin
        total = 0; bad = 0; t = 0;
        exp_valid = 0; exp_err = 0; exp_cnt = 0;
        for (int k = 0; k < 8; k++) begin exp_bf[k] = '0; d[k] = DW'(100 + k); end
        set_sel(0);
        @(negedge clk);
        tick(1, 0, 0);
        tick(1, 0, 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_cnt", int'(beat_cnt), 0);
        chk("rst_bf0", int'(bf[0]), 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0);

        // Directed table: single pulse latency, then reset with two reads in flight
        tbl[0] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{0, 0, 0, 0, 1, 0, 0, 100, 107};
        tbl[3] = '{0, 0, 0, 0, 0, 1, 0, 100, 107};
        tbl[4] = '{0, 1, 0, 1, 0, 1, 0, 100, 107};
        tbl[5] = '{0, 1, 0, 1, 0, 1, 0, 100, 107};
        tbl[6] = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[7] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[8] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
        for (int i = 0; i < 9; i++) begin
            set_sel(tbl[i].rev ? 1 : 0);
            tick(tbl[i].r, tbl[i].v, tbl[i].c);
            chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].ev));
            chk($sformatf("tbl%0d_cnt", i), int'(beat_cnt), tbl[i].ecnt);
            chk($sformatf("tbl%0d_last", i), int'(out_last), int'(tbl[i].elast));
            chk($sformatf("tbl%0d_bf0u", i), int'(bf[0]), tbl[i].eb0);
            chk($sformatf("tbl%0d_bf3l", i), int'(bf[7]), tbl[i].eb3);
        end

        // Nine back-to-back reversed beats over changing data: wrap and last
        set_sel(1);
        for (int i = 0; i < 13; i++) begin
            rand_data();
            tick(0, i < 9, 0);
            if (out_valid) begin
                q_cnt.push_back(int'(beat_cnt));
                q_last.push_back(int'(out_last));
            end
        end
        chk("wrap_nbeats", q_cnt.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < q_cnt.size()) begin
                chk($sformatf("wrap_cnt%0d", i), q_cnt[i], i % NB);
                chk($sformatf("wrap_last%0d", i), q_last[i], int'(i % NB == NB - 1));
            end
        end

        // stage_clr coincident with the third output beat
        tick(0, 0, 1);
        beats = 0;
        for (int i = 0; i < 8; i++) begin
            rand_data();
            if (out_valid) beats++;
            clr_now = out_valid && beats == 3;
            tick(0, i < 3, clr_now);
            if (clr_now) chk("clr_cnt", int'(beat_cnt), 0);
        end
        chk("clr_beats", beats, 3);

        // Duplicate selects: invalid beat must not flag, valid beat flags after LAT+1
        tick(0, 0, 1);
        set_sel(2);
        tick(0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0);
        chk("dup_invalid", int'(sel_err), 0);
        tick(0, 1, 0);
        set_sel(0);
        tick(0, 0, 0);
        chk("dup_early", int'(sel_err), 0);
        tick(0, 0, 0);
        chk("dup_set", int'(sel_err), int'(CHK));
        tick(0, 0, 0);
        chk("dup_sticky", int'(sel_err), int'(CHK));
        tick(0, 0, 1);
        chk("dup_clr", int'(sel_err), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rand_data();
            if ($urandom_range(3) != 0) begin
                for (int k = 0; k < 8; k++) p[k] = k;
                for (int k = 7; k > 0; k--) begin
                    int j = $urandom_range(k);
                    int tmp = p[k]; p[k] = p[j]; p[j] = tmp;
                end
                for (int k = 0; k < 8; k++) sel[k] = 3'(p[k]);
            end else begin
                for (int k = 0; k < 8; k++) sel[k] = 3'($urandom_range(7));
            end
            tick($urandom_range(49) == 0, $urandom_range(3) != 0, $urandom_range(15) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
